ps2_tx: RTL
===========

// Module: ps2_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs,
//  0xFF reset) to the keyboard over open-drain kbclk/kbdata. Companion of the
//  PS/2 receive path; drives lines only through active-high pull-low enables.
//  Frame: inhibit, start(0), 8 data LSB-first, odd parity, stop(1), device ACK.
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  system clock frequency
//  INHIBIT_US    100         clock-inhibit time before request-to-send
//  TIMEOUT_US    15000       watchdog limit, clock release to ACK (PS2_TX_TIMEOUT_EN only)
// PORTS
//  clk               in   1  system clock
//  rst_n             in   1  reset, asynchronous, active-low
//  kbclk             in   1  PS/2 clock line as seen at pin (async)
//  kbdata            in   1  PS/2 data line as seen at pin (async)
//  kbclk_drive_low   out  1  1 = pull kbclk low, 0 = release
//  kbdata_drive_low  out  1  1 = pull kbdata low, 0 = release
//  tx_data           in   8  byte to send, sampled on accept
//  tx_valid          in   1  request; accepted when tx_valid && tx_ready
//  tx_ready          out  1  1 only in IDLE
//  done              out  1  1-cycle pulse at end of every accepted transfer
//  err               out  1  valid with done: 1 = no ACK or timeout
// BEHAVIOUR
//  Reset: both drive_low=0, tx_ready=1, done=0, err=0, state IDLE. Async reset
//   mid-frame releases both lines immediately; no done pulse.
//  kbclk/kbdata pass 2-flop sync; fall = registered sync'd falling edge of kbclk.
//  IDLE: on accept, latch byte, par = ~^tx_data; tx_ready=0 next cycle.
//  INHIBIT: kbclk_drive_low=1 for INHIBIT_CYC = CLK_FREQ_HZ/1e6*INHIBIT_US cycles.
//  REQ: 1 cycle, kbclk_drive_low=1 and kbdata_drive_low=1 (start bit).
//  DATA: kbclk released, start held; bit counter 0..9. fall n (n=1..8) ->
//   kbdata_drive_low = ~byte[n-1]; fall 9 -> ~par; fall 10 -> 0 (stop, released).
//  ACK: fall 11: sample sync'd kbdata; low = ACK ok, high = err.
//  WAIT_IDLE: wait until sync'd kbclk=1 and kbdata=1 (no timeout here).
//  DONE: done=1 one cycle, err registered, tx_ready=1 next cycle -> IDLE.
//  tx_valid while busy ignored (not queued). err held until next accept.
//  Device-initiated traffic while IDLE is ignored (receive path owns it).
//  Counters sized $clog2 of max count; inhibit counter must not wrap.
// CONFIGURATION
//  PS2_TX_TIMEOUT_EN defined: cycle watchdog starts at REQ exit, cleared at ACK;
//   reaching TIMEOUT_CYC releases both lines, done=1, err=1, -> IDLE.
//  Undefined: no watchdog; block waits indefinitely for device clocks.
// STRUCTURE
//  Shared ps2_pkg.vh: state encodings (IDLE,INHIBIT,REQ,DATA,ACK,WAIT_IDLE,DONE),
//   frame bit count (11), us-to-cycle conversion macro, command constants
//   (PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA).
//  One sub-module: ps2_sync_edge (2-flop sync of kbclk/kbdata + kbclk falling-edge pulse).
// TESTING (device BFM: 40us clock period, samples on rise, ACK configurable)
//  Send 8'hED, BFM ACKs -> kbclk low 100us, BFM sees 0,1,0,1,1,0,1,1,1,par=1,stop=1; done=1 err=0.
//  Send 8'h00 -> parity bit 1; send 8'h01 -> parity 0; BFM-captured bytes match.
//  BFM withholds ACK -> done=1, err=1, both lines released, tx_ready=1 after.
//  tx_valid asserted with 8'hAA during 8'hED frame -> ignored; only 8'hED on wire.
//  rst_n low at bit 4 -> drive_low both 0 same cycle; next 8'hFF sends cleanly.
//  PS2_TX_TIMEOUT_EN, BFM never clocks -> done=1 err=1 after TIMEOUT_CYC; else stays busy.

Source files
------------

// File: rtl/ps2_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tx_pkg
//  Description : Shared definitions for the PS/2 host-to-device transmitter:
//                FSM state encoding, frame geometry, command byte constants
//                and a microsecond-to-clock-cycle conversion helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // Whole-MHz clocks assumed; the integer division truncates otherwise.
    function automatic int unsigned ps2_us_to_cyc(input int unsigned clk_hz,
                                                  input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tx_if
//  Description : Command-byte handshake between a requester and ps2_tx.
//                tx_data/tx_valid from the requester, tx_ready/done/err back.
//                master : requester side      slave : ps2_tx side
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output done,
        output err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_tx_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tx_sync_edge
//  Description : Two-flop synchronisers for the asynchronous PS/2 pins and a
//                registered one-cycle pulse on each synchronised kbclk fall.
//  Ports       : clk, rst_n        system clock, async active-low reset
//                kbclk, kbdata     raw pin levels
//                kbclk_s, kbdata_s synchronised levels
//                kbclk_fall        1-cycle pulse after a kbclk high->low
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx_sync_edge (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic kbclk,
    input  wire logic kbdata,
    output logic      kbclk_s,
    output logic      kbdata_s,
    output logic      kbclk_fall
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;
    logic r_fall;

    // Reset to the idle (released, pulled-up) line level so no false edge
    // is seen when reset lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_fall      <= 1'b0;
        end else begin
            r_clk_meta  <= kbclk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= kbdata;
            r_data_sync <= r_data_meta;
            r_fall      <= r_clk_prev & ~r_clk_sync;
        end
    end

    assign kbclk_s    = r_clk_sync;
    assign kbdata_s   = r_data_sync;
    assign kbclk_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tx
//  Description : PS/2 host-to-device transmitter. Sends one command byte to
//                the keyboard over open-drain kbclk/kbdata using active-high
//                pull-low enables: inhibit, request-to-send (start bit), 8 data
//                bits LSB first, odd parity, stop, then samples the device ACK.
//  Ports       : clk, rst_n         system clock, async active-low reset
//                kbclk, kbdata      pin levels (asynchronous)
//                kbclk_drive_low    1 = pull kbclk low
//                kbdata_drive_low   1 = pull kbdata low
//                tx_if (slave)      tx_data/tx_valid/tx_ready/done/err
//  Config      : PS2_TX_TIMEOUT_EN  enables a watchdog from clock release to
//                                   ACK; expiry releases lines, done+err.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_US  = 15000
`endif
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic kbclk,
    input  wire logic kbdata,
    output logic      kbclk_drive_low,
    output logic      kbdata_drive_low,
    ps2_tx_if.slave   tx_if
);

    localparam int c_INHIBIT_CYC = int'(ps2_us_to_cyc(CLK_FREQ_HZ, INHIBIT_US));
    localparam int c_INH_W       = $clog2(c_INHIBIT_CYC + 1);
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(c_INHIBIT_CYC - 1);

    // Falls 1..10 are counted 0..9 inside DATA; the 11th fall lands in ACK.
    localparam int c_BIT_W = $clog2(PS2_FRAME_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_PAR_IDX  = c_BIT_W'(PS2_FRAME_BITS - 3);
    localparam logic [c_BIT_W-1:0] c_STOP_IDX = c_BIT_W'(PS2_FRAME_BITS - 2);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int c_TIMEOUT_CYC = int'(ps2_us_to_cyc(CLK_FREQ_HZ, TIMEOUT_US));
    localparam int c_WDOG_W      = $clog2(c_TIMEOUT_CYC + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(c_TIMEOUT_CYC - 1);
`endif

    logic w_kbclk_s;
    logic w_kbdata_s;
    logic w_kbclk_fall;

    ps2_tx_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .kbclk      (kbclk),
        .kbdata     (kbdata),
        .kbclk_s    (w_kbclk_s),
        .kbdata_s   (w_kbdata_s),
        .kbclk_fall (w_kbclk_fall)
    );

    ps2_state_t         r_state;
    logic [7:0]         r_byte;
    logic               r_par;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_clk_low;
    logic               r_data_low;
    logic               r_tx_ready;
    logic               r_done;
    logic               r_err;
    logic               r_ack_err;
`ifdef PS2_TX_TIMEOUT_EN
    logic [c_WDOG_W-1:0] r_wdog;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_byte     <= 8'h00;
            r_par      <= 1'b0;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_tx_ready <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ack_err  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            r_wdog     <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Device-initiated traffic here belongs to the receive path.
                    if (tx_if.tx_valid && r_tx_ready) begin
                        r_byte     <= tx_if.tx_data;
                        r_par      <= ~^tx_if.tx_data;
                        r_err      <= 1'b0;
                        r_ack_err  <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_clk_low  <= 1'b1;
                        r_inh_cnt  <= '0;
                        r_state    <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_inh_cnt == c_INH_LAST) begin
                        r_data_low <= 1'b1;
                        r_state    <= ST_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end

                ST_REQ: begin
                    // Releasing the clock with data held low is the
                    // request-to-send; the device now starts clocking.
                    r_clk_low <= 1'b0;
                    r_bit_cnt <= '0;
                    r_state   <= ST_DATA;
                end

                ST_DATA: begin
                    if (w_kbclk_fall) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_STOP_IDX) begin
                            r_data_low <= 1'b0;
                            r_state    <= ST_ACK;
                        end else if (r_bit_cnt == c_PAR_IDX) begin
                            r_data_low <= ~r_par;
                        end else begin
                            r_data_low <= ~r_byte[r_bit_cnt[2:0]];
                        end
                    end
                end

                ST_ACK: begin
                    if (w_kbclk_fall) begin
                        r_ack_err <= w_kbdata_s;
                        r_state   <= ST_WAIT_IDLE;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (w_kbclk_s && w_kbdata_s) begin
                        r_done  <= 1'b1;
                        r_err   <= r_ack_err;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_tx_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_clk_low  <= 1'b0;
                    r_data_low <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog spans clock release to ACK sample; placed after the
            // case so an expiry overrides whatever the case scheduled.
            if (r_state == ST_DATA || r_state == ST_ACK) begin
                if (r_wdog == c_WDOG_LAST) begin
                    r_clk_low  <= 1'b0;
                    r_data_low <= 1'b0;
                    r_done     <= 1'b1;
                    r_err      <= 1'b1;
                    r_state    <= ST_DONE;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

    assign kbclk_drive_low  = r_clk_low;
    assign kbdata_drive_low = r_data_low;
    assign tx_if.tx_ready   = r_tx_ready;
    assign tx_if.done       = r_done;
    assign tx_if.err        = r_err;

endmodule
`default_nettype wire
